instr_dcd: RTL and testbench

Instruction decoder between the SPI bridge and the PWM register file. Turns the received byte stream into register-file accesses. Each frame is one command byte followed by one data byte. The block drives the register file's read/write strobes, address, byte-select and write data, and captures the register file's read data for the bridge to shift out.

---
 rtl/pwm_regs_pkg.sv | 43 ++++
 rtl/instr_dcd.sv | 106 ++++++++++
 tb/tb_instr_dcd.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_regs_pkg.sv
// Shared PWM register map and SPI command-byte layout.
// Used by the instruction decoder and the register file.
package pwm_regs_pkg;

   localparam logic [5:0] ADDR_PERIOD      = 6'h00;
   localparam logic [5:0] ADDR_COUNTER_EN  = 6'h02;
   localparam logic [5:0] ADDR_COMPARE1    = 6'h03;
   localparam logic [5:0] ADDR_COMPARE2    = 6'h05;
   localparam logic [5:0] ADDR_COUNTER_RST = 6'h07;
   localparam logic [5:0] ADDR_COUNTER_VAL = 6'h08;
   localparam logic [5:0] ADDR_PRESCALE    = 6'h0A;
   localparam logic [5:0] ADDR_UPNOTDOWN   = 6'h0B;
   localparam logic [5:0] ADDR_PWM_EN      = 6'h0C;
   localparam logic [5:0] ADDR_FUNCTIONS   = 6'h0D;

   localparam int CMD_RW_BIT = 7;
   localparam int CMD_HB_BIT = 6;

   function automatic logic addr_valid(input logic [5:0] a);
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (a == ADDR_PERIOD),
         (a == ADDR_COUNTER_EN),
         (a == ADDR_COMPARE1),
         (a == ADDR_COMPARE2),
         (a == ADDR_COUNTER_RST),
         (a == ADDR_COUNTER_VAL),
         (a == ADDR_PRESCALE),
         (a == ADDR_UPNOTDOWN),
         (a == ADDR_PWM_EN),
         (a == ADDR_FUNCTIONS): ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // counter_val is the only read-only register
   function automatic logic addr_writable(input logic [5:0] a);
      return addr_valid(a) && (a != ADDR_COUNTER_VAL);
   endfunction

endpackage

// File: rtl/instr_dcd.sv
// SPI frame decoder: command byte + data byte -> register-file access.
// Ports: clk/rst_n, cs_n, byte_sync/data_in from bridge; data_read from
// regfile; read/write/addr/high_byte/data_write to regfile; data_out to
// bridge; cmd_err pulse on rejected command.
module instr_dcd
   import pwm_regs_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              byte_sync,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_read,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic              high_byte,
   output logic [DATA_W-1:0] data_write,
   output logic [DATA_W-1:0] data_out,
   output logic              cmd_err
);

   typedef enum logic {ST_CMD, ST_DATA} state_t;

   state_t r_state;
   state_t w_nxt;

   logic       r_is_wr;
   logic       r_valid;
   logic       r_rd_err;
   logic       w_take;
   logic       w_wr;
   logic       w_ok;
   logic [5:0] w_a;

   assign w_take = byte_sync && !cs_n;
   assign w_wr   = data_in[CMD_RW_BIT];
   assign w_a    = data_in[5:0];
   assign w_ok   = w_wr ? addr_writable(w_a) : addr_valid(w_a);

   always_comb begin
      w_nxt = r_state;
      if (cs_n) begin
         w_nxt = ST_CMD;
      end else if (byte_sync) begin
         unique case (r_state)
            ST_CMD:  w_nxt = ST_DATA;
            ST_DATA: w_nxt = ST_CMD;
            default: w_nxt = ST_CMD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_CMD;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read       <= 1'b0;
         write      <= 1'b0;
         cmd_err    <= 1'b0;
         addr       <= '0;
         high_byte  <= 1'b0;
         data_write <= '0;
         data_out   <= '0;
         r_is_wr    <= 1'b0;
         r_valid    <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         read     <= 1'b0;
         write    <= 1'b0;
         cmd_err  <= 1'b0;
         r_rd_err <= 1'b0;
         // read strobe was issued last cycle; regfile data is now valid
         if (read) begin
            data_out <= data_read;
         end else if (r_rd_err) begin
            data_out <= '0;
         end
         if (w_take && r_state == ST_CMD) begin
            addr      <= data_in[ADDR_W-1:0];
            high_byte <= data_in[CMD_HB_BIT];
            r_is_wr   <= w_wr;
            r_valid   <= w_ok;
            read      <= w_ok && !w_wr;
            cmd_err   <= !w_ok;
            r_rd_err  <= !w_ok && !w_wr;
         end
         if (w_take && r_state == ST_DATA) begin
            if (r_valid && r_is_wr) begin
               data_write <= data_in;
               write      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_dcd.sv
// Self-checking bench for instr_dcd: directed frames plus random traffic
// compared every cycle against a frame-level behavioural model.
module tb_instr_dcd;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs_n = 1'b1;
   logic       byte_sync = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_read;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic       high_byte;
   logic [7:0] data_write;
   logic [7:0] data_out;
   logic       cmd_err;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [128];

   always #5 clk = ~clk;

   assign data_read = mem[{high_byte, addr}];

   instr_dcd #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
      .byte_sync(byte_sync), .data_in(data_in),
      .data_read(data_read), .read(read), .write(write),
      .addr(addr), .high_byte(high_byte),
      .data_write(data_write), .data_out(data_out),
      .cmd_err(cmd_err)
   );

   // ---------------- behavioural model ----------------
   logic [7:0] legal_list [10] = '{8'h00, 8'h02, 8'h03, 8'h05, 8'h07,
                                   8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D};

   function automatic logic legal(input logic [5:0] a, input logic wr);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 10; i++)
         if ({2'b00, a} == legal_list[i]) found = 1'b1;
      if (wr && a == 6'h08) found = 1'b0;
      return found;
   endfunction

   logic       m_cmd = 1'b1;
   logic       m_pwr = 1'b0;
   logic       m_pok = 1'b0;
   logic       m_read = 1'b0;
   logic       m_write = 1'b0;
   logic       m_err = 1'b0;
   logic [5:0] m_addr = 6'h00;
   logic       m_hb = 1'b0;
   logic [7:0] m_dw = 8'h00;
   logic [7:0] m_dout = 8'h00;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cmd <= 1'b1; m_pwr <= 1'b0; m_pok <= 1'b0;
         m_read <= 1'b0; m_write <= 1'b0; m_err <= 1'b0;
         m_addr <= 6'h00; m_hb <= 1'b0;
         m_dw <= 8'h00; m_dout <= 8'h00;
      end else begin
         m_read <= 1'b0; m_write <= 1'b0; m_err <= 1'b0;
         if (m_read) m_dout <= mem[{m_hb, m_addr}];
         else if (m_err && !m_pwr) m_dout <= 8'h00;
         if (cs_n) begin
            m_cmd <= 1'b1;
         end else if (byte_sync) begin
            if (m_cmd) begin
               m_addr <= data_in[5:0];
               m_hb   <= data_in[6];
               m_pwr  <= data_in[7];
               m_pok  <= legal(data_in[5:0], data_in[7]);
               m_read <= legal(data_in[5:0], data_in[7]) && !data_in[7];
               m_err  <= !legal(data_in[5:0], data_in[7]);
               m_cmd  <= 1'b0;
            end else begin
               if (m_pok && m_pwr) begin
                  m_dw <= data_in;
                  m_write <= 1'b1;
               end
               m_cmd <= 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%02h expected 0x%02h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic cmp_all();
      chk("read", {7'd0, read}, {7'd0, m_read});
      chk("write", {7'd0, write}, {7'd0, m_write});
      chk("cmd_err", {7'd0, cmd_err}, {7'd0, m_err});
      chk("addr", {2'd0, addr}, {2'd0, m_addr});
      chk("high_byte", {7'd0, high_byte}, {7'd0, m_hb});
      chk("data_write", data_write, m_dw);
      chk("data_out", data_out, m_dout);
      chk("rd_wr_excl", {7'd0, read & write}, 8'h00);
   endtask

   // drive for one cycle, then compare just after the edge
   task automatic cyc(input logic rst, input logic cs,
                      input logic bs, input logic [7:0] d);
      rst_n = rst; cs_n = cs; byte_sync = bs; data_in = d;
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic sb(input logic [7:0] d);
      cyc(1'b1, 1'b0, 1'b1, d);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[{1'b1, 6'h00}] = 8'h12;
      mem[{1'b0, 6'h0C}] = 8'hA7;
      @(posedge clk); #1;
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("rst_read", {7'd0, read}, 8'h00);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_addr", {2'd0, addr}, 8'h00);

      // write prescale low
      sb(8'h8A);
      chk("w0a_noread", {7'd0, read}, 8'h00);
      sb(8'h05);
      chk("w0a_write", {7'd0, write}, 8'h01);
      chk("w0a_addr", {2'd0, addr}, 8'h0A);
      chk("w0a_dw", data_write, 8'h05);

      // read period high
      sb(8'h40);
      chk("r00_read", {7'd0, read}, 8'h01);
      chk("r00_hb", {7'd0, high_byte}, 8'h01);
      sb(8'hFF);
      chk("r00_dout", data_out, 8'h12);
      chk("r00_nowr", {7'd0, write}, 8'h00);

      // illegal writes
      sb(8'h88);
      chk("w08_err", {7'd0, cmd_err}, 8'h01);
      sb(8'h55);
      chk("w08_nowr", {7'd0, write}, 8'h00);
      sb(8'h81);
      chk("w01_err", {7'd0, cmd_err}, 8'h01);
      sb(8'h55);
      chk("w01_nowr", {7'd0, write}, 8'h00);

      // cs_n abort
      sb(8'h8D);
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      sb(8'h3C);
      chk("abort_err", {7'd0, cmd_err}, 8'h01);
      chk("abort_nowr", {7'd0, write}, 8'h00);
      chk("abort_addr", {2'd0, addr}, 8'h3C);
      sb(8'h00);

      // reset mid-frame
      sb(8'h83);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("mrst_addr", {2'd0, addr}, 8'h00);
      chk("mrst_dout", data_out, 8'h00);
      sb(8'h77);
      chk("mrst_err", {7'd0, cmd_err}, 8'h01);
      chk("mrst_addr2", {2'd0, addr}, 8'h37);
      sb(8'h00);

      // back-to-back
      sb(8'h8C);
      sb(8'h01);
      chk("b2b_write", {7'd0, write}, 8'h01);
      chk("b2b_dw", data_write, 8'h01);
      sb(8'h0C);
      chk("b2b_read", {7'd0, read}, 8'h01);
      sb(8'h00);
      chk("b2b_dout", data_out, 8'hA7);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] d;
         logic r, c, b;
         d = 8'($urandom);
         if ($urandom_range(0, 3) != 0)
            d[5:0] = legal_list[$urandom_range(0, 9)][5:0];
         r = ($urandom_range(0, 99) != 0);
         c = ($urandom_range(0, 19) == 0);
         b = ($urandom_range(0, 1) == 1);
         cyc(r, c, b, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
